// File: rtl/barker_sync_detector.sv
// barker_sync_detector: streaming Barker-code correlator with a peak detector
// and a period-tracking lock FSM.
// Stage A registers the sample window and its correlation sum.
// Stage B registers the detection result, FSM state and the output beat.
// Both stages advance together on a single global enable, so backpressure on
// the master side simply freezes the whole pipe.
module barker_sync_detector #(
  parameter int  SAMPLE_W = 4,
  parameter int  CODE_LEN = 13,
  parameter int  THRESH   = 64,
  parameter int  PERIOD   = 13,
  parameter int  MISS_MAX = 3,
  localparam int CORR_W   = SAMPLE_W + $clog2(CODE_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SAMPLE_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [CORR_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [2:0]        m_axis_tuser
);

  localparam int STAGES = 2;
  localparam int FILL_W = $clog2(CODE_LEN + 1);
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam int ABS_W  = CORR_W + 1;

  // Parameter legality is checked at elaboration.
  if (!(CODE_LEN == 7 || CODE_LEN == 11 || CODE_LEN == 13)) begin : g_bad_code_len
    $error("barker_sync_detector: CODE_LEN must be 7, 11 or 13");
  end
  if (PERIOD < 2) begin : g_bad_period
    $error("barker_sync_detector: PERIOD must be >= 2");
  end
  if (MISS_MAX < 1) begin : g_bad_miss_max
    $error("barker_sync_detector: MISS_MAX must be >= 1");
  end

  // Chip table: bit k = 1 means chip k is '+'; chip 0 is transmitted first.
  function automatic logic [CODE_LEN-1:0] barker_code();
    logic [CODE_LEN-1:0] c;
    c = '0;
    case (CODE_LEN)
      7:       c = CODE_LEN'(7'b0100111);
      11:      c = CODE_LEN'(11'b01001000111);
      13:      c = CODE_LEN'(13'b1010110011111);
      default: c = '0;
    endcase
    return c;
  endfunction

  localparam logic [CODE_LEN-1:0] CODE = barker_code();

  function automatic logic signed [CORR_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    return {{(CORR_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  typedef enum logic {SEARCH, LOCKED} state_t;

  // Stage A payload: correlation of the window including this beat, its tlast,
  // and whether the window was full when it was evaluated.
  typedef struct packed {
    logic signed [CORR_W-1:0] corr;
    logic                     last;
    logic                     full;
  } stage_a_t;

  logic [STAGES:1] vld_pipe_q;
  logic            en;
  logic            accept;

  logic [CODE_LEN-1:0][SAMPLE_W-1:0] win_q, win_d, win_shift;
  logic [FILL_W-1:0]                 fill_q, fill_d, fill_inc;
  logic signed [CORR_W-1:0]          corr_new;
  stage_a_t                          a_q, a_d;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [MISS_W-1:0]  miss_q, miss_inc;
  logic [CORR_W-1:0]  tdata_q;
  logic [2:0]         tuser_q;
  logic               tlast_q;

  logic signed [ABS_W-1:0] corr_ext, abs_b;
  logic                    neg_b, raw_b, slot_b, hit_b;

  // One enable for the whole pipe: move whenever the output slot is free or drained.
  assign en            = !vld_pipe_q[STAGES] | m_axis_tready;
  assign s_axis_tready = en & ~i_rst;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Window shifts in the new sample at the top; oldest sample falls out of slot 0.
  assign win_shift = {s_axis_tdata, win_q[CODE_LEN-1:1]};
  assign fill_inc  = (fill_q == FILL_W'(CODE_LEN)) ? fill_q : fill_q + FILL_W'(1);

  // Exact correlation of the post-shift window against the chip table.
  always_comb begin
    corr_new = '0;
    for (int k = 0; k < CODE_LEN; k++) begin
      if (CODE[k]) corr_new = corr_new + sext(win_shift[k]);
      else         corr_new = corr_new - sext(win_shift[k]);
    end
  end

  // Next window/fill: a tlast beat is evaluated normally, then the window empties.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    a_d    = a_q;
    if (accept) begin
      win_d   = s_axis_tlast ? '0 : win_shift;
      fill_d  = s_axis_tlast ? '0 : fill_inc;
      a_d.corr = corr_new;
      a_d.last = s_axis_tlast;
      a_d.full = (fill_inc == FILL_W'(CODE_LEN));
    end
  end

  // Valid shift register; bubbles move forward like beats do.
  always_ff @(posedge i_clk) begin
    if (i_rst)   vld_pipe_q <= '0;
    else if (en) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], accept};
  end

  // Stage A state: window, fill count and the evaluated beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_q  <= '0;
      fill_q <= '0;
      a_q    <= '0;
    end else if (en) begin
      win_q  <= win_d;
      fill_q <= fill_d;
      a_q    <= a_d;
    end
  end

  // Stage B detection terms; |corr| widened by one bit so the most negative value fits.
  assign corr_ext = {a_q.corr[CORR_W-1], a_q.corr};
  assign neg_b    = a_q.corr[CORR_W-1];
  assign abs_b    = neg_b ? -corr_ext : corr_ext;
  assign raw_b    = vld_pipe_q[1] & a_q.full & (int'(abs_b) >= THRESH);
  assign slot_b   = (cnt_q == CNT_W'(PERIOD - 1));
  assign hit_b    = raw_b & slot_b;
  assign miss_inc = miss_q + MISS_W'(1);

  // Lock FSM and registered output beat; only real beats advance the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      miss_q  <= '0;
      tdata_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
    end else if (en && vld_pipe_q[1]) begin
      tdata_q <= a_q.corr;
      tlast_q <= a_q.last;
      case (state_q)
        SEARCH: begin
          tuser_q <= {raw_b & neg_b, raw_b, raw_b};
          if (raw_b) begin
            state_q <= LOCKED;
            cnt_q   <= '0;
            miss_q  <= '0;
          end
        end
        LOCKED: begin
          // Only the expected slot is flagged; off-slot sidelobes are ignored.
          tuser_q <= {hit_b & neg_b, 1'b1, hit_b};
          cnt_q   <= slot_b ? '0 : cnt_q + CNT_W'(1);
          if (slot_b) begin
            if (raw_b) begin
              miss_q <= '0;
            end else if (miss_inc == MISS_W'(MISS_MAX)) begin
              state_q <= SEARCH;
              miss_q  <= '0;
            end else begin
              miss_q <= miss_inc;
            end
          end
        end
        default: state_q <= SEARCH;
      endcase
      // End of packet wins over any hit or lock decided on the same beat.
      if (a_q.last) begin
        state_q <= SEARCH;
        cnt_q   <= '0;
        miss_q  <= '0;
      end
    end
  end

  assign m_axis_tvalid = vld_pipe_q[STAGES];
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_barker_sync_detector.sv
// Bench for barker_sync_detector: directed steps feed a reference model that
// queues expected output beats; each DUT output beat is popped and compared.
module tb_barker_sync_detector;
  localparam int SAMPLE_W = 4;
  localparam int CODE_LEN = 13;
  localparam int THRESH   = 64;
  localparam int PERIOD   = 13;
  localparam int MISS_MAX = 3;
  localparam int CORR_W   = SAMPLE_W + $clog2(CODE_LEN + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SAMPLE_W-1:0] s_tdata = '0;
  logic                s_tvalid = 1'b0;
  logic                s_tlast = 1'b0;
  logic                s_tready;
  logic [CORR_W-1:0]   m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tready = 1'b1;
  logic [2:0]          m_tuser;

  barker_sync_detector dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int user; int last; int acc_cyc; } exp_t;
  exp_t sb[$];
  int   obs_d[$];
  int   obs_u[$];
  int   nvec = 0, nerr = 0, cyc = 0, n_pushed = 0;
  bit   chk_lat = 1'b0, rnd = 1'b0, accepted = 1'b0, stall = 1'b0;
  logic [CORR_W-1:0] held = '0;
  int   code [CODE_LEN] = '{1, 1, 1, 1, 1, -1, -1, 1, 1, -1, 1, -1, 1};

  // reference model state
  int mw [CODE_LEN];
  int mfill, mcnt, mmiss;
  bit mlock;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(o), $signed(e));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < CODE_LEN; k++) mw[k] = 0;
    mfill = 0; mcnt = 0; mmiss = 0; mlock = 1'b0;
  endtask

  task automatic model_beat(input int x, input bit last);
    exp_t e;
    int   corr, a;
    bit   raw, pk, lk, slot;
    for (int k = 0; k < CODE_LEN - 1; k++) mw[k] = mw[k+1];
    mw[CODE_LEN-1] = x;
    if (mfill < CODE_LEN) mfill++;
    corr = 0;
    for (int k = 0; k < CODE_LEN; k++) corr += mw[k] * code[k];
    a   = (corr < 0) ? -corr : corr;
    raw = (a >= THRESH) && (mfill >= CODE_LEN);
    pk  = 1'b0;
    lk  = 1'b0;
    if (!mlock) begin
      pk = raw; lk = raw;
      if (raw) begin mlock = 1'b1; mcnt = 0; mmiss = 0; end
    end else begin
      lk   = 1'b1;
      slot = (mcnt == PERIOD - 1);
      pk   = slot && raw;
      mcnt = slot ? 0 : mcnt + 1;
      if (slot) begin
        if (raw) mmiss = 0;
        else begin
          mmiss++;
          if (mmiss == MISS_MAX) begin mlock = 1'b0; mmiss = 0; end
        end
      end
    end
    if (last) begin
      for (int k = 0; k < CODE_LEN; k++) mw[k] = 0;
      mfill = 0; mlock = 1'b0; mcnt = 0; mmiss = 0;
    end
    e.data    = corr;
    e.user    = ((pk && corr < 0) ? 4 : 0) + (lk ? 2 : 0) + (pk ? 1 : 0);
    e.last    = last ? 1 : 0;
    e.acc_cyc = cyc;
    sb.push_back(e);
    n_pushed++;
  endtask

  function automatic int obs_data(input int i);
    if (i >= 0 && i < obs_d.size()) return obs_d[i];
    return -9999;
  endfunction

  function automatic int obs_user(input int i);
    if (i >= 0 && i < obs_u.size()) return obs_u[i];
    return -1;
  endfunction

  // One clock: evaluate handshakes mid-cycle, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst) begin
      sb.delete();
      model_clear();
      n_pushed = obs_d.size();
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_tvalid", 32'(m_tvalid), 32'd1);
        check("hold_tdata", 32'(m_tdata), 32'(held));
      end
      if (s_tvalid && s_tready) begin
        model_beat(int'($signed(s_tdata)), s_tlast);
        accepted = 1'b1;
      end
      if (m_tvalid && m_tready) begin
        nvec++;
        assert (sb.size() != 0) else begin
          nerr++;
          $error("FAIL unexpected_beat: observed data %0d expected no beat", $signed(m_tdata));
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("tdata", 32'($signed(m_tdata)), e.data);
          check("tuser", 32'(m_tuser), e.user);
          check("tlast", 32'(m_tlast), e.last);
          if (chk_lat) check("latency", cyc - e.acc_cyc, 2);
          obs_d.push_back(int'($signed(m_tdata)));
          obs_u.push_back(int'(m_tuser));
        end
      end
      stall = m_tvalid && !m_tready;
      held  = m_tdata;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input bit last);
    s_tvalid = 1'b1;
    s_tdata  = SAMPLE_W'(x);
    s_tlast  = last;
    if (rnd) m_tready = 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i < 100 && !accepted; i++) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    check("accept_in_time", 32'(accepted), 32'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_code(input int amp);
    for (int k = 0; k < CODE_LEN; k++) send(amp * code[k], 1'b0);
  endtask

  task automatic drain();
    rnd = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
    tick();
    tick();
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int base, a;
    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tdata", 32'(m_tdata), 0);
    check("rst_tuser", 32'(m_tuser), 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_tready", 32'(s_tready), 0);
    rst = 1'b0;
    #1;
    check("tready_after_rst", 32'(s_tready), 1);

    // positive code: peak +91 on beat 13, two cycles after acceptance
    chk_lat = 1'b1;
    base = n_pushed;
    send_code(7);
    drain();
    check("pos_corr", obs_data(base + 12), 91);
    check("pos_user", obs_user(base + 12), 3);
    check("pos_prev_user", obs_user(base + 11), 0);

    // negative code after an end-of-packet beat
    send(0, 1'b1);
    base = n_pushed;
    send_code(-7);
    drain();
    check("neg_corr", obs_data(base + 12), -91);
    check("neg_user", obs_user(base + 12), 7);

    // three back-to-back codes, 40 zero beats to lose lock, then relock
    send(0, 1'b1);
    base = n_pushed;
    repeat (3) send_code(7);
    repeat (40) send(0, 1'b0);
    send_code(7);
    drain();
    for (int i = 12; i < 39; i++) begin
      check("locked_bit", (obs_user(base + i) >> 1) & 1, 1);
      check("peak_bit", obs_user(base + i) & 1, (i == 12 || i == 25 || i == 38) ? 1 : 0);
      if (i != 12 && i != 25 && i != 38) begin
        a = obs_data(base + i);
        check("sidelobe_le7", (a <= 7 && a >= -7) ? 1 : 0, 1);
      end
    end
    check("third_miss_locked", (obs_user(base + 77) >> 1) & 1, 1);
    check("after_miss_unlocked", (obs_user(base + 78) >> 1) & 1, 0);
    check("relock_user", obs_user(base + 91), 3);
    check("relock_corr", obs_data(base + 91), 91);
    chk_lat = 1'b0;

    // random backpressure with random samples, codes and a mid-stream tlast
    send(0, 1'b1);
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 15)) - 8, i == 20);
    send_code(7);
    send_code(-7);
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 15)) - 8, 1'b0);
    drain();

    // tlast on chip 6 while locked; the remaining 7 chips must not peak
    send(0, 1'b1);
    base = n_pushed;
    send_code(7);
    for (int k = 0; k < 6; k++) send(7 * code[k], k == 5);
    for (int k = 6; k < CODE_LEN; k++) send(7 * code[k], 1'b0);
    drain();
    check("lock_before_tlast", obs_user(base + 12), 3);
    for (int i = 13; i < 19; i++) check("locked_thru_tlast", obs_user(base + i), 2);
    for (int i = 19; i < 26; i++) check("search_after_tlast", obs_user(base + i), 0);

    // one-cycle reset with beats in flight, then a clean code
    for (int i = 0; i < 5; i++) send(7 * code[i], 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tvalid", 32'(m_tvalid), 0);
    tick();
    check("mid_rst_idle", 32'(m_tvalid), 0);
    base = n_pushed;
    send_code(-7);
    drain();
    check("post_rst_corr", obs_data(base + 12), -91);
    check("post_rst_user", obs_user(base + 12), 7);
    check("post_rst_prev", obs_user(base + 11), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/barker_sync_detector.md
BARKER_SYNC_DETECTOR -- requirements
Module: barker_sync_detector

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 4, signed soft-sample width.
REQ-002 SHALL have parameter CODE_LEN, default 13, Barker length, legal values 7/11/13; any other value is an elaboration error.
REQ-003 SHALL have parameter THRESH, default 64, peak threshold on |corr|.
REQ-004 SHALL have parameter PERIOD, default 13, beats between expected peaks when locked (>=2).
REQ-005 SHALL have parameter MISS_MAX, default 3, consecutive missed peaks that drop lock (>=1).
REQ-006 SHALL define CORR_W = SAMPLE_W + $clog2(CODE_LEN+1).
REQ-007 i_clk  in  1  sole clock; all logic on rising edge.
REQ-008 i_rst  in  1  reset; synchronous, active-high.
REQ-009 s_axis_tdata  in  SAMPLE_W  signed soft sample.
REQ-010 s_axis_tvalid  in  1;  s_axis_tlast  in  1 (end of packet);  s_axis_tready  out  1.
REQ-011 m_axis_tdata  out  CORR_W  signed correlation value.
REQ-012 m_axis_tvalid  out  1;  m_axis_tlast  out  1;  m_axis_tready  in  1.
REQ-013 m_axis_tuser  out  3  [0]=peak, [1]=locked, [2]=polarity (1 = negative corr).

Function
REQ-014 Codes (c[0] first transmitted): 7 = +++--+-, 11 = +++---+--+-, 13 = +++++--++-+-+.
REQ-015 Each accepted input beat (tvalid & tready) SHALL shift into a CODE_LEN window, w[0] oldest, w[CODE_LEN-1] newest; empty slots hold 0.
REQ-016 corr = sum over k of w[k]*c[k], exact in CORR_W bits, no saturation or truncation.
REQ-017 Two-stage pipeline (A: window + sum register, B: detect/FSM + output register); with m_axis_tready=1 output appears exactly 2 cycles after the input beat is accepted.
REQ-018 Global advance en = !m_axis_tvalid | m_axis_tready; s_axis_tready = en; with en=0, all stages, window, counters and FSM SHALL hold.
REQ-019 Exactly one output beat per accepted input beat; order preserved; no beat dropped or duplicated.
REQ-020 Peak raw condition: |corr| >= THRESH and fill count >= CODE_LEN (fill counts accepted beats since reset/tlast, saturating at CODE_LEN).
REQ-021 FSM states SEARCH, LOCKED; reset state SEARCH.
REQ-022 SEARCH: tuser[0] = raw peak; on raw peak go LOCKED, period counter := 0, miss count := 0.
REQ-023 LOCKED: period counter increments per output beat, wraps PERIOD-1 -> 0; tuser[0] only when raw peak and counter reaches PERIOD-1 (expected slot); off-slot peaks are not flagged.
REQ-024 LOCKED expected slot: hit -> miss count := 0; miss -> miss count++; reaching MISS_MAX -> SEARCH on that beat.
REQ-025 tuser[1] = 1 on every beat evaluated while LOCKED, including the beat that causes lock; tuser[2] = sign of corr when tuser[0]=1, else 0.
REQ-026 m_axis_tlast mirrors input tlast of the same beat.
REQ-027 After an accepted tlast beat, window and fill count SHALL clear before the next beat; when that beat reaches stage B, FSM goes SEARCH; tlast takes priority over a simultaneous hit or lock on the same beat, but that beat's tuser still reports its own evaluation.

Reset
REQ-028 With i_rst=1 at a clock edge: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, window/fill/counters=0, FSM=SEARCH, all in-flight beats discarded.
REQ-029 s_axis_tready SHALL be 0 while i_rst=1 and 1 the first cycle after release (pipeline empty).
REQ-030 Reset mid-packet SHALL behave identically to power-on; no partial window survives.

Verification
REQ-031 Defaults, 13 chips of +7*c[k], ready=1 -> beat 13 output corr=+91 two cycles later, tuser=3'b011.
REQ-032 Same with -7*c[k] -> corr=-91, tuser=3'b111.
REQ-033 Three back-to-back codes -> peaks at beats 13, 26, 39, all tuser[1]=1; off-slot sidelobes (|corr|<=7) never flagged.
REQ-034 Lock, then 3 periods of zeros -> tuser[1] is 0 starting on the beat after the third missed slot; a later code relocks.
REQ-035 Random m_axis_tready 50% -> output sequence equals zero-stall golden model beat for beat; tdata held stable while tvalid & !tready.
REQ-036 tlast at chip 6 of a code, then the remaining 7 chips -> no peak (fill < 13), FSM in SEARCH; i_rst for 1 cycle mid-stream -> tvalid=0 next cycle, later outputs consistent with clean start.
